// File: rtl/divisor_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Holds the FSM state encoding, counter sizing and two's-complement negation.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_e;

    localparam int unsigned MAX_WIDTH = 32;

    // Step counter width for a given operand width; it counts WIDTH-1 down to 0.
    function automatic int unsigned cnt_width(input int unsigned w);
        return int'($clog2(w));
    endfunction

    // Callers truncate the result back to their own operand width.
    function automatic logic [MAX_WIDTH-1:0] twos_neg(input logic [MAX_WIDTH-1:0] v);
        return (~v) + {{(MAX_WIDTH-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/divisor_passo.sv
// One combinational restoring-division step: shift in the next dividend bit,
// then trial-subtract the divisor from the partial remainder.
module divisor_passo #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic             dvd_msb_i,
    input  logic [WIDTH-1:0] dvs_i,
    output logic [WIDTH-1:0] rem_o,
    output logic             q_bit_o
);

    // The shifted remainder needs WIDTH+1 bits so the compare cannot overflow;
    // the stored remainder is always below the divisor and fits in WIDTH bits.
    logic [WIDTH:0] trial;

    assign trial   = {rem_i, dvd_msb_i};
    assign q_bit_o = (trial >= {1'b0, dvs_i});
    assign rem_o   = q_bit_o ? WIDTH'(trial - {1'b0, dvs_i}) : trial[WIDTH-1:0];

endmodule

// File: rtl/divisor_seq_nbits.sv
// Sequential restoring divider, one quotient bit per cycle, signed or unsigned
// per operation, with start/busy/done handshake and div-by-zero/overflow flags.
module divisor_seq_nbits
    import divisor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             div_zero,
    output logic             overflow
);

    localparam int unsigned     CNT_W   = cnt_width(WIDTH);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;       // |A| shifting out, quotient shifting in
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             a_neg_q, a_neg_d;   // already masked by signed_mode
    logic             b_neg_q, b_neg_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             dz_out_q, dz_out_d;
    logic             ovf_out_q, ovf_out_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic             a_neg_in, b_neg_in;

    assign a_neg_in = signed_mode & A[WIDTH-1];
    assign b_neg_in = signed_mode & B[WIDTH-1];

    divisor_passo #(.WIDTH(WIDTH)) u_passo (
        .rem_i     (rem_q),
        .dvd_msb_i (dvd_q[WIDTH-1]),
        .dvs_i     (dvs_q),
        .rem_o     (step_rem),
        .q_bit_o   (step_q)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        a_neg_d   = a_neg_q;
        b_neg_d   = b_neg_q;
        dz_d      = dz_q;
        ovf_d     = ovf_q;
        q_d       = q_q;
        r_d       = r_q;
        dz_out_d  = dz_out_q;
        ovf_out_d = ovf_out_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_neg_d = a_neg_in;
                    b_neg_d = b_neg_in;
                    dvd_d   = a_neg_in ? WIDTH'(twos_neg(MAX_WIDTH'(A))) : A;
                    dvs_d   = b_neg_in ? WIDTH'(twos_neg(MAX_WIDTH'(B))) : B;
                    rem_d   = '0;
                    cnt_d   = CNT_W'(WIDTH - 1);
                    dz_d    = (B == '0);
                    ovf_d   = signed_mode && (A == MIN_VAL) && (B == '1);
                    state_d = (B == '0) ? FIX : CALC;
                end
            end
            CALC: begin
                rem_d = step_rem;
                dvd_d = {dvd_q[WIDTH-2:0], step_q};
                if (cnt_q == '0) begin
                    state_d = FIX;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIX: begin
                state_d   = IDLE;
                done_d    = 1'b1;
                dz_out_d  = dz_q;
                ovf_out_d = ovf_q;
                if (dz_q) begin
                    q_d = '1;
                    r_d = '0;
                end else begin
                    q_d = (a_neg_q ^ b_neg_q) ? WIDTH'(twos_neg(MAX_WIDTH'(dvd_q))) : dvd_q;
                    r_d = a_neg_q ? WIDTH'(twos_neg(MAX_WIDTH'(rem_q))) : rem_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only; all registers,
    // datapath included, are cleared so an aborted operation leaves no residue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            dz_q      <= 1'b0;
            ovf_q     <= 1'b0;
            q_q       <= '0;
            r_q       <= '0;
            dz_out_q  <= 1'b0;
            ovf_out_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            a_neg_q   <= a_neg_d;
            b_neg_q   <= b_neg_d;
            dz_q      <= dz_d;
            ovf_q     <= ovf_d;
            q_q       <= q_d;
            r_q       <= r_d;
            dz_out_q  <= dz_out_d;
            ovf_out_q <= ovf_out_d;
            done_q    <= done_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign Q        = q_q;
    assign R        = r_q;
    assign div_zero = dz_out_q;
    assign overflow = ovf_out_q;

endmodule

// File: doc/divisor_seq_nbits.md
Name: divisor_seq_nbits

Overview:
- Parametrised sequential restoring divider for the ULA datapath. Successor to the combinational 8-bit divider.
- Operand width is a parameter; unsigned or signed operation is selected per operation; produces one quotient bit per cycle.
- Start/busy/done handshake lets the ULA top level issue a divide and wait for the result.
- Divide-by-zero and signed-overflow conditions are flagged explicitly.

Parameters:
- WIDTH, 8, operand/quotient/remainder width in bits (legal range 2..32).

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request a new division; sampled only in IDLE
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
- A  input  WIDTH  dividend; captured with start
- B  input  WIDTH  divisor; captured with start
- busy  output  1  high while an operation is in progress
- done  output  1  one-cycle pulse when Q/R/flags are valid
- Q  output  WIDTH  quotient; held until the next accepted start
- R  output  WIDTH  remainder; held until the next accepted start
- div_zero  output  1  B was zero for the last operation; held with Q/R
- overflow  output  1  signed MIN / -1 for the last operation; held with Q/R

Behaviour:
- Reset (rst_n low, asynchronous):
  - State goes to IDLE.
  - busy, done, div_zero, overflow = 0; Q = 0; R = 0; internal registers cleared.
  - Reset mid-operation aborts the operation. No done pulse is produced for it.
- States: IDLE, CALC, FIX.
- IDLE:
  - On start=1 at edge 0: capture signed_mode, the sign of A and the sign of B.
  - Capture |A| and |B| (absolute values only when signed_mode=1).
  - Clear the partial remainder and load the step counter with WIDTH-1. busy=1 from edge 0.
  - If B==0, go to FIX directly. Otherwise go to CALC.
- CALC, once per cycle:
  - Shift {rem, dvd} left by 1.
  - If rem >= |B|, then rem -= |B| and shift in quotient bit 1; else shift in 0.
  - rem is WIDTH+1 bits wide so the compare never overflows.
  - After WIDTH cycles, go to FIX.
- FIX (one cycle): register the outputs on exit, then go to IDLE.
  - Outputs registered on exit:
    - Q = quotient, negated if signed_mode and sign(A)≠sign(B).
    - R = rem, negated if signed_mode and A was negative.
    - This gives truncation toward zero, with the remainder taking the sign of the dividend.
  - Status on the same edge: done=1 for exactly one cycle; busy=0.
- Latency:
  - Normal operation: done is visible after edge WIDTH+1 (WIDTH+1 cycles from start).
  - B==0: done is visible after edge 1.
  - New start accepted: the earliest is the cycle done is high (state is IDLE then).
- Divide by zero: Q = all ones, R = 0, div_zero=1, overflow=0, in both modes.
- Signed overflow: signed_mode=1, A = MIN (1 followed by zeros), B = all ones (-1):
  - Q = MIN (wrapped), R = 0, overflow=1.
  - The normal cycle count still applies.
- Unsigned mode never sets overflow.
- start while busy: ignored, with no effect on the operation in flight. The input operand changes after capture are also ignored.
- Q/R/div_zero/overflow change only on the FIX exit edge. Between operations they hold their last value.
- All arithmetic is modulo 2^WIDTH except the WIDTH+1-bit partial remainder.

Decomposition:
- Shared package divisor_pkg:
  - State enum (IDLE, CALC, FIX).
  - Localparam for counter width = clog2(WIDTH).
  - Helper function for WIDTH-bit two's-complement absolute value/negation.
- One natural sub-module: divisor_passo. It is the combinational single restoring step:
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
  - It is instantiated once inside the CALC datapath.
- No other hierarchy.

Test Plan:
- WIDTH=8, unsigned, A=200, B=7, start 1 cycle -> busy high 9 cycles, done pulse after edge 9, Q=28, R=4, flags 0.
- WIDTH=8, signed, A=-7 (0xF9), B=2 -> Q=-3 (0xFD), R=-1 (0xFF); then A=7, B=-2 -> Q=0xFD, R=0x01.
- B=0 (unsigned, A=55) -> done after edge 1, Q=0xFF, R=0x00, div_zero=1; next normal op clears div_zero.
- Signed A=0x80, B=0xFF -> Q=0x80, R=0x00, overflow=1, done after edge 9.
- start pulsed again at cycle 3 with A=1, B=1 during an op A=100, B=10 -> ignored; result Q=10, R=0; back-to-back start in the done cycle accepted.
- rst_n low at cycle 4 of an op -> busy/done/Q/R zero immediately (asynchronous), no done pulse; after release, a new op A=255, B=16 -> Q=15, R=15. Repeat with WIDTH=16: A=50000, B=123 -> Q=406, R=62, 17-cycle latency.
